// File: rtl/servo_pkg.sv
// Shared defaults, duty helper and packed duty-vector type for the multi-channel servo PWM stage.
package servo_pkg;

  localparam int unsigned CANT_BITS_DEF = 16;
  localparam int unsigned PWM_BITS_DEF  = 8;
  localparam int unsigned N_CH_DEF      = 2;

  typedef logic [N_CH_DEF-1:0][PWM_BITS_DEF-1:0] duty_vec_t;

  // Largest duty value; also the period length in ticks.
  function automatic int unsigned duty_max(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/servo_pwm_mc_if.sv
// Sample stream from the PID/rounding stage: packed signed samples plus per-channel strobes.
interface servo_pwm_mc_if #(
    parameter int unsigned N_CH      = servo_pkg::N_CH_DEF,
    parameter int unsigned CANT_BITS = servo_pkg::CANT_BITS_DEF
);

    logic [N_CH*CANT_BITS-1:0] Yk_in;
    logic [N_CH-1:0]           Yk_valid;

    modport master (output Yk_in, output Yk_valid);
    modport slave  (input Yk_in, input Yk_valid);

endinterface

// File: rtl/servo_sat_round.sv
// Combinational round-half-up, arithmetic shift and saturation of one signed sample to a duty.
module servo_sat_round
    import servo_pkg::*;
#(
    parameter int unsigned CANT_BITS = CANT_BITS_DEF,
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned SHIFT     = CANT_BITS - PWM_BITS - 1
) (
    input  logic signed [CANT_BITS-1:0] yk,
    output logic        [PWM_BITS-1:0]  duty,
    output logic                        sat
);

    localparam logic signed [CANT_BITS:0] Half = (CANT_BITS + 1)'(1) <<< (SHIFT - 1);
    localparam logic signed [CANT_BITS:0] MaxD = (CANT_BITS + 1)'(duty_max(PWM_BITS));

    logic signed [CANT_BITS:0] sum;
    logic signed [CANT_BITS:0] r;

    // One extra bit keeps the rounding add from overflowing at the positive rail.
    always_comb begin
        sum  = {yk[CANT_BITS-1], yk} + Half;
        r    = sum >>> SHIFT;
        duty = '0;
        sat  = 1'b0;
        if (r[CANT_BITS]) begin
            sat = 1'b1;
        end else if (r > MaxD) begin
            duty = '1;
            sat  = 1'b1;
        end else begin
            duty = r[PWM_BITS-1:0];
        end
    end

endmodule

// File: rtl/servo_pwm_mc.sv
// N-channel servo PWM output stage with shadow/active duty double-buffering and tick prescaler.
// Optional sticky saturation flags are built when SERVO_PWM_SAT_FLAG_EN is defined.
module servo_pwm_mc
    import servo_pkg::*;
#(
    parameter int unsigned CANT_BITS  = CANT_BITS_DEF,
    parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
    parameter int unsigned SHIFT      = CANT_BITS - PWM_BITS - 1,
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned PRESC_BITS = 12
) (
    input  logic                     Clk_P,
    input  logic                     Rst_P,
    input  logic                     Enable,
    input  logic [PRESC_BITS-1:0]    Presc,
    servo_pwm_mc_if.slave            smp,
    output logic [N_CH-1:0]          PWM_out,
    output logic [N_CH*PWM_BITS-1:0] Duty_act,
    output logic                     Period_start
`ifdef SERVO_PWM_SAT_FLAG_EN
    ,
    output logic [N_CH-1:0]          Sat_flag
`endif
);

    localparam logic [PWM_BITS-1:0] PMax = PWM_BITS'(duty_max(PWM_BITS) - 1);

    logic [PRESC_BITS-1:0]         pres_q;
    logic [PWM_BITS-1:0]           cnt_q;
    logic [N_CH-1:0][PWM_BITS-1:0] shadow_q;
    logic [N_CH-1:0][PWM_BITS-1:0] active_q;
    logic [N_CH-1:0][PWM_BITS-1:0] duty_w;
    logic [N_CH-1:0]               sat_w;
    logic [N_CH-1:0]               pwm_q;
    logic                          period_start_q;
    logic                          tick;
    logic                          wrap;

    // >= so that lowering Presc below the running count ticks straight away.
    assign tick = Enable && (pres_q >= Presc);
    assign wrap = tick && (cnt_q == PMax);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        servo_sat_round #(
            .CANT_BITS (CANT_BITS),
            .PWM_BITS  (PWM_BITS),
            .SHIFT     (SHIFT)
        ) u_sat_round (
            .yk   (smp.Yk_in[k*CANT_BITS +: CANT_BITS]),
            .duty (duty_w[k]),
            .sat  (sat_w[k])
        );
    end

    always_ff @(posedge Clk_P or negedge Rst_P) begin
        if (!Rst_P) begin
            pres_q         <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            active_q       <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (smp.Yk_valid[k]) shadow_q[k] <= duty_w[k];
            end
            if (!Enable) begin
                pres_q         <= '0;
                cnt_q          <= '0;
                pwm_q          <= '0;
                period_start_q <= 1'b0;
            end else begin
                pres_q         <= tick ? '0 : pres_q + 1'b1;
                period_start_q <= wrap;
                if (tick) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
                // Old shadow is taken here, so a sample landing on this edge waits a period.
                if (wrap) active_q <= shadow_q;
                for (int unsigned k = 0; k < N_CH; k++) begin
                    pwm_q[k] <= (cnt_q < active_q[k]);
                end
            end
        end
    end

    assign PWM_out      = pwm_q;
    assign Duty_act     = active_q;
    assign Period_start = period_start_q;

`ifdef SERVO_PWM_SAT_FLAG_EN
    logic [N_CH-1:0] sat_q;
    logic            enable_q;

    always_ff @(posedge Clk_P or negedge Rst_P) begin
        if (!Rst_P) begin
            sat_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= Enable;
            sat_q    <= ((enable_q && !Enable) ? '0 : sat_q) | (smp.Yk_valid & sat_w);
        end
    end

    assign Sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = ^sat_w;
`endif

endmodule

// File: tb/tb_servo_pwm_mc.sv
// Scoreboard bench for servo_pwm_mc: stimulus pushes expected active duties per wrap,
// a negedge monitor pops them at each Period_start and checks duty, high time and lag.
module tb_servo_pwm_mc;
    import servo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [11:0] presc;
    logic [1:0]  PWM_out;
    logic [15:0] Duty_act;
    logic        Period_start;
`ifdef SERVO_PWM_SAT_FLAG_EN
    logic [1:0]  Sat_flag;
`endif

    int n_checks = 0;
    int n_err    = 0;

    servo_pwm_mc_if #(.N_CH(2), .CANT_BITS(16)) smp ();

    servo_pwm_mc dut (
        .Clk_P        (clk),
        .Rst_P        (rst_n),
        .Enable       (en),
        .Presc        (presc),
        .smp          (smp),
        .PWM_out      (PWM_out),
        .Duty_act     (Duty_act),
        .Period_start (Period_start)
`ifdef SERVO_PWM_SAT_FLAG_EN
        ,
        .Sat_flag     (Sat_flag)
`endif
    );

    always #5 clk = ~clk;

    // Reference: floor((yk + 64) / 128) clamped to [0, 255].
    function automatic int ref_round(input int yk);
        int s;
        s = yk + 64;
        return (s >= 0) ? s / 128 : -((-s + 127) / 128);
    endfunction

    function automatic int ref_duty(input int yk);
        int r;
        r = ref_round(yk);
        if (r < 0) return 0;
        if (r > 255) return 255;
        return r;
    endfunction

    function automatic bit ref_sat(input int yk);
        int r;
        r = ref_round(yk);
        return (r < 0) || (r > 255);
    endfunction

    function automatic int rand_yk();
        logic [15:0] v;
        v = 16'($urandom);
        unique case ($urandom_range(0, 3))
            0: return int'($signed(v));
            1: return int'($urandom_range(0, 32639));
            2: return int'($urandom_range(32500, 32767));
            default: return -int'($urandom_range(0, 300));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    duty_vec_t exp_q[$];
    duty_vec_t sh;
    bit [1:0]  satm;
    bit        mon_en;

    task automatic issue(input bit v0, input int y0, input bit v1, input int y1);
        logic [15:0] a;
        logic [15:0] b;
        a = y0[15:0];
        b = y1[15:0];
        smp.Yk_in    = {b, a};
        smp.Yk_valid = {v1, v0};
        if (v0) begin sh[0] = 8'(ref_duty(y0)); satm[0] = satm[0] | ref_sat(y0); end
        if (v1) begin sh[1] = 8'(ref_duty(y1)); satm[1] = satm[1] | ref_sat(y1); end
        @(posedge clk); #1;
        smp.Yk_valid = 2'b00;
    endtask

    task automatic wait_ps(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 255 * (int'(presc) + 1) + 20) begin
            @(negedge clk);
            if (Period_start) seen = 1;
            else n++;
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: no Period_start within %0d clocks", name, n);
        end
    endtask

    task automatic measure_first_ps(input int expect_clks, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < expect_clks + 50) begin
            @(negedge clk);
            if (Period_start) seen = 1;
            else n++;
        end
        check(name, 32'(n), 32'(expect_clks));
    endtask

    // Called just after a Period_start: sample mid-period, expect it at the next wrap.
    task automatic period_step(input bit v0, input int y0, input bit v1, input int y1,
                               input string name);
        repeat ($urandom_range(3, 100)) @(posedge clk);
        #1;
        if (v0 || v1) issue(v0, y0, v1, y1);
        exp_q.push_back(sh);
        wait_ps(name);
    endtask

    duty_vec_t cur_exp;
    bit        armed = 0;
    bit        en_last = 0;
    int        hi_cnt[2];

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (!en_last) begin
                check("dis_pwm", 32'(PWM_out), 32'(0));
                check("dis_ps", 32'(Period_start), 32'(0));
                armed = 0;
            end else if (Period_start) begin
                if (armed) begin
                    for (int k = 0; k < 2; k++) begin
                        check($sformatf("high_time_ch%0d", k), 32'(hi_cnt[k] + int'(PWM_out[k])),
                              32'(int'(cur_exp[k]) * (int'(presc) + 1)));
                        check($sformatf("lag_ch%0d", k), 32'(PWM_out[k]),
                              32'(cur_exp[k] == 8'd255));
                    end
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_empty: got wrap expected none");
                    armed = 0;
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("duty_act", 32'(Duty_act), 32'(cur_exp));
                    armed = 1;
                    hi_cnt[0] = 0;
                    hi_cnt[1] = 0;
                end
            end else if (armed) begin
                for (int k = 0; k < 2; k++) hi_cnt[k] += int'(PWM_out[k]);
            end
        end else begin
            armed = 0;
        end
        en_last = en;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        presc = 12'd0;
        smp.Yk_in = '0;
        smp.Yk_valid = '0;
        mon_en = 0;
        sh = '0;
        satm = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", 32'(PWM_out), 32'(0));
        check("rst_duty", 32'(Duty_act), 32'(0));
        check("rst_ps", 32'(Period_start), 32'(0));
`ifdef SERVO_PWM_SAT_FLAG_EN
        check("rst_sat", 32'(Sat_flag), 32'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;

        // Sample while disabled, then start: ch0 16384 -> 128.
        issue(1, 16384, 1, 0);
        exp_q.push_back(sh);
        en = 1'b1;
        measure_first_ps(255, "first_ps_p0");

        period_step(1, 32767, 1, -32768, "sat");
`ifdef SERVO_PWM_SAT_FLAG_EN
        check("sat_flag", 32'(Sat_flag), 32'(satm));
`endif
        period_step(1, 191, 1, 192, "round");
        period_step(1, 1280, 0, 0, "duty10");

        // Sample for 200 lands exactly on the next wrap edge.
        exp_q.push_back(sh);
        repeat (255 * (int'(presc) + 1) - 1) @(posedge clk);
        #1;
        issue(1, 25600, 0, 0);
        exp_q.push_back(sh);
        wait_ps("coinc_wrap1");
        wait_ps("coinc_wrap2");

        for (int i = 0; i < 6; i++) begin
            period_step(1'($urandom_range(0, 1)), rand_yk(), 1'($urandom_range(0, 1)), rand_yk(),
                        "random");
        end

        // Asynchronous reset mid-period with ch0 output high.
        period_step(1, 32767, 1, 0, "pre_reset");
        repeat (30) @(posedge clk);
        #1;
        check("pre_reset_pwm0", 32'(PWM_out[0]), 32'(1));
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(PWM_out), 32'(0));
        check("async_rst_duty", 32'(Duty_act), 32'(0));
        check("async_rst_ps", 32'(Period_start), 32'(0));
`ifdef SERVO_PWM_SAT_FLAG_EN
        check("async_rst_sat", 32'(Sat_flag), 32'(0));
`endif
        sh = '0;
        satm = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1;
        exp_q.push_back(sh);
        measure_first_ps(255, "first_ps_after_reset");

        period_step(1, -32768, 1, 192, "pre_disable");
`ifdef SERVO_PWM_SAT_FLAG_EN
        check("sat_pre_disable", 32'(Sat_flag), 32'(satm));
`endif

        // Disable for 50 clocks, switch to Presc=3, resume.
        @(posedge clk); #1;
        en = 1'b0;
        satm = '0;
        exp_q.delete();
        presc = 12'd3;
        repeat (5) @(posedge clk);
        #1;
`ifdef SERVO_PWM_SAT_FLAG_EN
        check("sat_cleared", 32'(Sat_flag), 32'(satm));
`endif
        issue(1, 32767, 1, 16384);
        repeat (44) @(posedge clk);
        #1;
        check("dis_duty_held", 32'(Duty_act), 32'({8'd2, 8'd0}));
`ifdef SERVO_PWM_SAT_FLAG_EN
        check("sat_while_dis", 32'(Sat_flag), 32'(satm));
`endif
        exp_q.push_back(sh);
        en = 1'b1;
        measure_first_ps(1020, "first_ps_p3");
        period_step(1, rand_yk(), 1, rand_yk(), "p3_a");
        period_step(1, 6400, 1, 1000, "p3_b");
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
